// File: rtl/reg_file_sb_pkg.sv
// Shared register-file definitions: clear-engine states and the default
// datapath widths used by decode and writeback.
package reg_file_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Issue/writeback/read bundle between the pipeline and the register file.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     clr_req;
  logic                     clr_busy;
  logic [ADDR_W:0]          pend_cnt;

  modport master (
    output rd_addr, iss_valid, iss_addr, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data, rd_busy, clr_busy, pend_cnt
  );

  modport slave (
    input  rd_addr, iss_valid, iss_addr, wr_en, wr_addr, wr_data, clr_req,
    output rd_data, rd_busy, clr_busy, pend_cnt
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one bit per entry, set on issue, cleared on
// commit or flush, with a registered popcount and per-port lookup.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_pend,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pend_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // Issue is applied after commit so a same-address pair stays pending.
  always_comb begin
    pend_nxt = pending;
    if (wr_en)
      pend_nxt[wr_addr] = 1'b0;
    if (iss_valid && !((ZERO_REG != 0) && (iss_addr == '0)))
      pend_nxt[iss_addr] = 1'b1;
    if (flush)
      pend_nxt = '0;
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
    assign rd_pend[k] = pending[rd_addr[k*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write bypass, optional zero register,
// pending-write scoreboard and a one-entry-per-cycle clear engine.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  clr_state_t        state;
  logic              clr_busy_q;
  logic [ADDR_W-1:0] idx;
  logic              wr_ok;
  logic              iss_ok;
  logic              flush;
  logic [NUM_RD-1:0] rd_pend;
  logic [ADDR_W:0]   pend_cnt_q;

  assign wr_ok  = bus.wr_en && !clr_busy_q && !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign iss_ok = bus.iss_valid && !clr_busy_q;
  assign flush  = (state == IDLE) && bus.clr_req;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      clr_busy_q <= 1'b0;
      idx        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state      <= CLEAR;
            clr_busy_q <= 1'b1;
            idx        <= '0;
          end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
          end
        end
        CLEAR: begin
          mem[idx] <= '0;
          idx      <= idx + 1'b1;
          if (idx == ADDR_W'(DEPTH-1)) begin
            state      <= IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  reg_file_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .Clk      (Clk),
    .Reset    (Reset),
    .iss_valid(iss_ok),
    .iss_addr (bus.iss_addr),
    .wr_en    (wr_ok),
    .wr_addr  (bus.wr_addr),
    .flush    (flush),
    .rd_addr  (bus.rd_addr),
    .rd_pend  (rd_pend),
    .pend_cnt (pend_cnt_q)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    // Clear overrides busy last so every port stalls while the engine runs.
    always_comb begin
      data = mem[addr];
      busy = rd_pend[k];
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end else if ((BYPASS != 0) && wr_ok && (bus.wr_addr == addr)) begin
        data = bus.wr_data;
        busy = 1'b0;
      end
      if (clr_busy_q)
        busy = 1'b1;
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[k]                  = busy;
  end

  assign bus.clr_busy = clr_busy_q;
  assign bus.pend_cnt = pend_cnt_q;

endmodule
